line_follow_ctrl: RTL and testbench
===================================

// Module: line_follow_ctrl
// PURPOSE
//   Closed-loop drive sequencer for the line-following car. Consumes the 3-bit tracker
//   state and the ultrasonic stop flag; drives per-wheel direction codes plus a speed
//   mode for the PWM motor block. Sits between tracker_sensor/sonic_top and motor.
//   Adds turn dwell, lost-line search with timeout, and filtered obstacle stop/resume.
// PARAMETERS
//   MIN_DWELL       100_000     min cycles in a drive state before another line-driven change
//   SEARCH_TIMEOUT  50_000_000  cycles in SEARCH (line lost) before HALT
//   STOP_FILTER     1_000       consecutive stop=1 cycles required to enter OBSTACLE
//   RESUME_DELAY    25_000_000  consecutive stop=0 cycles required to leave OBSTACLE
// PORTS
//   clk         in   1  system clock
//   rst         in   1  asynchronous, active-high reset
//   en          in   1  run enable; 0 forces IDLE
//   line_state  in   3  [2]=left, [1]=mid, [0]=right sensor on line (1 = on line)
//   stop        in   1  obstacle flag from ultrasonic block
//   left        out  2  left wheel direction: 2'b10 fwd, 2'b01 rev, 2'b00 off
//   right       out  2  right wheel direction, same encoding
//   mode        out  3  speed code to motor: 0 off, 1 cruise, 2 soft turn, 3 pivot
//   fsm_state   out  3  current state encoding, for LEDs and debug
// BEHAVIOUR
//   - Reset: state IDLE; left=right=2'b00; mode=0; all counters 0. Outputs are registered.
//   - Latency: a new input that causes a transition updates all outputs on the next clk edge.
//   - States (output left/right/mode):
//       IDLE 00/00/0   FWD 10/10/1   SOFT_L 00/10/2   SOFT_R 10/00/2
//       HARD_L 01/10/3  HARD_R 10/01/3  SEARCH as last turn dir (HARD_L/HARD_R,
//       HARD_L if none)  OBSTACLE 00/00/0  HALT 00/00/0
//   - Line decode, evaluated only when the dwell counter is at least MIN_DWELL:
//       010,111 -> FWD; 110 -> SOFT_L; 100 -> HARD_L; 011 -> SOFT_R; 001 -> HARD_R;
//       000 -> SEARCH; 101 -> hold the current state.
//   - Dwell counter clears on every state change and saturates at MIN_DWELL.
//   - IDLE -> FWD when en=1. en=0 from any state -> IDLE on the next edge,
//     which also clears all counters.
//   - Stop filter counts consecutive stop=1 cycles. When the count reaches STOP_FILTER,
//     the FSM goes to OBSTACLE from any drive state or SEARCH, ignoring dwell.
//     A stop=0 cycle clears the filter.
//   - OBSTACLE: the resume counter counts consecutive stop=0 cycles. When it reaches
//     RESUME_DELAY, the FSM goes to FWD with dwell cleared. A stop=1 cycle clears the counter.
//   - SEARCH: the timer counts from entry. Any nonzero line_state (subject to dwell) leaves
//     per the line decode. The timer reaching SEARCH_TIMEOUT -> HALT.
//   - HALT: sticky. Exit only via en=0 (-> IDLE) or rst.
//   - Priority within a cycle: rst > en=0 > obstacle entry > timeout > line decode.
//   - Remembered turn direction updates on entry to any SOFT_*/HARD_* state.
//     FWD does not clear it.
//   - Counter width: $clog2(param+1). Counters saturate and never wrap.
//   - Reset asserted mid-operation: outputs reach 00/00/0 asynchronously.
// STRUCTURE
//   - car_pkg: direction codes (DIR_FWD/DIR_REV/DIR_OFF), mode codes, FSM state
//     localparams, line pattern constants.
//   - Sub-module sat_counter (parameter MAX; ports clr, inc, done): used for dwell,
//     stop filter, resume and search timers.
//   - line_follow_ctrl: FSM, registered output decode, turn-memory register.
// TESTING  (bench overrides: MIN_DWELL=4, SEARCH_TIMEOUT=20, STOP_FILTER=3, RESUME_DELAY=5)
//   1. rst pulse mid-FWD -> left=right=00, mode=0 immediately. After release with en=1,
//      FWD (10/10/1) one cycle later.
//   2. FWD, line_state 010->100 before dwell=4 -> stays FWD. At dwell=4 -> HARD_L
//      01/10/3 on the next edge. 101 then holds HARD_L.
//   3. After SOFT_R, line_state=000 -> SEARCH driving 10/01/3. 20 cycles of 000 -> HALT 00/00/0.
//      010 afterwards is ignored; en 1->0->1 -> IDLE then FWD.
//   4. stop=1 for 2 cycles, then 0 -> no OBSTACLE. stop=1 for 3 cycles -> OBSTACLE 00/00/0,
//      entered even mid-dwell.
//   5. In OBSTACLE: stop=0 for 4 cycles, then stop=1 for 1 cycle, then stop=0 for 5 cycles
//      -> FWD only after the final 5-cycle run.
//   6. Same cycle: stop filter expires and search timeout hits -> OBSTACLE wins.
//      en=0 in the same cycle -> IDLE wins.

Source files
------------

// File: rtl/car_pkg.sv
// Shared encodings for the line-following car: wheel direction codes, speed modes,
// controller states and tracker line patterns, plus the state-to-drive decode.
package car_pkg;

  localparam logic [1:0] DIR_FWD = 2'b10;
  localparam logic [1:0] DIR_REV = 2'b01;
  localparam logic [1:0] DIR_OFF = 2'b00;

  localparam logic [2:0] MODE_OFF    = 3'd0;
  localparam logic [2:0] MODE_CRUISE = 3'd1;
  localparam logic [2:0] MODE_SOFT   = 3'd2;
  localparam logic [2:0] MODE_PIVOT  = 3'd3;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FWD      = 4'd1,
    ST_SOFT_L   = 4'd2,
    ST_SOFT_R   = 4'd3,
    ST_HARD_L   = 4'd4,
    ST_HARD_R   = 4'd5,
    ST_SEARCH   = 4'd6,
    ST_OBSTACLE = 4'd7,
    ST_HALT     = 4'd8
  } state_t;

  localparam logic [2:0] LINE_LOST   = 3'b000;
  localparam logic [2:0] LINE_CENTER = 3'b010;
  localparam logic [2:0] LINE_ALL    = 3'b111;
  localparam logic [2:0] LINE_SOFT_L = 3'b110;
  localparam logic [2:0] LINE_HARD_L = 3'b100;
  localparam logic [2:0] LINE_SOFT_R = 3'b011;
  localparam logic [2:0] LINE_HARD_R = 3'b001;
  localparam logic [2:0] LINE_SPLIT  = 3'b101;

  typedef struct packed {
    logic [1:0] left;
    logic [1:0] right;
    logic [2:0] mode;
  } drive_t;

  // SEARCH pivots toward whichever side the line was last seen on.
  function automatic drive_t drive_of(state_t s, logic turn_left);
    drive_t d;
    d.left  = DIR_OFF;
    d.right = DIR_OFF;
    d.mode  = MODE_OFF;
    case (s)
      ST_FWD:    begin d.left = DIR_FWD; d.right = DIR_FWD; d.mode = MODE_CRUISE; end
      ST_SOFT_L: begin d.left = DIR_OFF; d.right = DIR_FWD; d.mode = MODE_SOFT;   end
      ST_SOFT_R: begin d.left = DIR_FWD; d.right = DIR_OFF; d.mode = MODE_SOFT;   end
      ST_HARD_L: begin d.left = DIR_REV; d.right = DIR_FWD; d.mode = MODE_PIVOT;  end
      ST_HARD_R: begin d.left = DIR_FWD; d.right = DIR_REV; d.mode = MODE_PIVOT;  end
      ST_SEARCH: begin
        if (turn_left) begin
          d.left = DIR_REV; d.right = DIR_FWD;
        end else begin
          d.left = DIR_FWD; d.right = DIR_REV;
        end
        d.mode = MODE_PIVOT;
      end
      default: ;
    endcase
    return d;
  endfunction

  // Nine states share a 3-bit debug code, so HALT reuses OBSTACLE's code (both stopped).
  function automatic logic [2:0] state_code(state_t s);
    return (s == ST_HALT) ? 3'd7 : 3'(s);
  endfunction

endpackage

// File: rtl/line_follow_ctrl_if.sv
// Sensor-in / motor-out bundle between the tracker and sonic blocks, the
// controller, and the PWM motor block.
interface line_follow_ctrl_if;
  logic       en;
  logic [2:0] line_state;
  logic       stop;
  logic [1:0] left;
  logic [1:0] right;
  logic [2:0] mode;
  logic [2:0] fsm_state;

  modport master (
    output en, line_state, stop,
    input  left, right, mode, fsm_state
  );

  modport slave (
    input  en, line_state, stop,
    output left, right, mode, fsm_state
  );
endinterface

// File: rtl/line_follow_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear. EARLY=0 flags once the count sits at
// MAX; EARLY=1 flags on the cycle whose increment lands on (or holds) MAX.
module sat_counter #(
  parameter int unsigned MAX   = 4,
  parameter bit          EARLY = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic done
);

  localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_W = W'(MAX);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_W)) begin
      count <= count + W'(1);
    end
  end

  assign done = EARLY ? (!clr && inc && (count >= (MAX_W - W'(1))))
                      : (count == MAX_W);

endmodule

// File: rtl/line_follow_ctrl.sv
// Closed-loop drive sequencer: decodes tracker patterns into wheel commands with turn
// dwell, lost-line search with timeout, and filtered obstacle stop/resume.
module line_follow_ctrl
  import car_pkg::*;
#(
  parameter int unsigned MIN_DWELL      = 100_000,
  parameter int unsigned SEARCH_TIMEOUT = 50_000_000,
  parameter int unsigned STOP_FILTER    = 1_000,
  parameter int unsigned RESUME_DELAY   = 25_000_000
) (
  input logic               clk,
  input logic               rst,
  line_follow_ctrl_if.slave bus
);

  state_t state;
  state_t state_next;
  state_t line_target;
  logic   turn_left;
  logic   turn_left_next;
  drive_t drive_next;

  logic dwell_done;
  logic stop_hit;
  logic resume_hit;
  logic search_hit;
  logic dwell_clr;
  logic stop_clr;
  logic resume_clr;
  logic search_clr;

  assign dwell_clr  = !bus.en || (state_next != state);
  assign stop_clr   = !bus.en || !bus.stop;
  assign resume_clr = !bus.en || bus.stop || (state != ST_OBSTACLE);
  assign search_clr = !bus.en || (state != ST_SEARCH);

  sat_counter #(.MAX(MIN_DWELL), .EARLY(1'b0)) u_dwell (
    .clk(clk), .rst(rst), .clr(dwell_clr), .inc(1'b1), .done(dwell_done)
  );

  sat_counter #(.MAX(STOP_FILTER), .EARLY(1'b1)) u_stop_filter (
    .clk(clk), .rst(rst), .clr(stop_clr), .inc(bus.stop), .done(stop_hit)
  );

  sat_counter #(.MAX(RESUME_DELAY), .EARLY(1'b1)) u_resume (
    .clk(clk), .rst(rst), .clr(resume_clr), .inc(!bus.stop), .done(resume_hit)
  );

  sat_counter #(.MAX(SEARCH_TIMEOUT), .EARLY(1'b1)) u_search (
    .clk(clk), .rst(rst), .clr(search_clr), .inc(1'b1), .done(search_hit)
  );

  always_comb begin
    line_target = state;
    case (bus.line_state)
      LINE_CENTER, LINE_ALL: line_target = ST_FWD;
      LINE_SOFT_L:           line_target = ST_SOFT_L;
      LINE_HARD_L:           line_target = ST_HARD_L;
      LINE_SOFT_R:           line_target = ST_SOFT_R;
      LINE_HARD_R:           line_target = ST_HARD_R;
      LINE_LOST:             line_target = ST_SEARCH;
      default:               line_target = state;
    endcase
  end

  // Priority: en=0, then obstacle entry, then search timeout, then dwell-gated line decode.
  always_comb begin
    state_next = state;
    if (!bus.en) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     state_next = ST_FWD;
        ST_HALT:     state_next = ST_HALT;
        ST_OBSTACLE: if (resume_hit) state_next = ST_FWD;
        default: begin
          if (stop_hit) begin
            state_next = ST_OBSTACLE;
          end else if ((state == ST_SEARCH) && search_hit) begin
            state_next = ST_HALT;
          end else if (dwell_done) begin
            state_next = line_target;
          end
        end
      endcase
    end
  end

  always_comb begin
    turn_left_next = turn_left;
    case (state_next)
      ST_SOFT_L, ST_HARD_L: turn_left_next = 1'b1;
      ST_SOFT_R, ST_HARD_R: turn_left_next = 1'b0;
      default:              turn_left_next = turn_left;
    endcase
    drive_next = drive_of(state_next, turn_left_next);
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      turn_left     <= 1'b1;
      bus.left      <= DIR_OFF;
      bus.right     <= DIR_OFF;
      bus.mode      <= MODE_OFF;
      bus.fsm_state <= 3'd0;
    end else begin
      state         <= state_next;
      turn_left     <= turn_left_next;
      bus.left      <= drive_next.left;
      bus.right     <= drive_next.right;
      bus.mode      <= drive_next.mode;
      bus.fsm_state <= state_code(state_next);
    end
  end

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Self-checking bench for line_follow_ctrl: directed scenarios plus random stimulus,
// all compared against a cycle-level behavioural model of the car's rules.
module tb_line_follow_ctrl;

  localparam int MIN_DWELL      = 4;
  localparam int SEARCH_TIMEOUT = 20;
  localparam int STOP_FILTER    = 3;
  localparam int RESUME_DELAY   = 5;

  logic clk = 1'b0;
  logic rst;

  line_follow_ctrl_if bus ();

  line_follow_ctrl #(
    .MIN_DWELL(MIN_DWELL),
    .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
    .STOP_FILTER(STOP_FILTER),
    .RESUME_DELAY(RESUME_DELAY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef enum int {
    M_IDLE, M_FWD, M_SOFT_L, M_SOFT_R, M_HARD_L, M_HARD_R, M_SEARCH, M_OBSTACLE, M_HALT
  } mstate_t;

  mstate_t m_state;
  int      m_age;
  int      m_stop_run;
  int      m_clear_run;
  bit      m_turn_left;

  int total;
  int bad;

  task automatic model_reset();
    m_state     = M_IDLE;
    m_age       = 0;
    m_stop_run  = 0;
    m_clear_run = 0;
    m_turn_left = 1'b1;
  endtask

  function automatic mstate_t decode_line(logic [2:0] l, mstate_t cur);
    case (l)
      3'b010, 3'b111: return M_FWD;
      3'b110:         return M_SOFT_L;
      3'b100:         return M_HARD_L;
      3'b011:         return M_SOFT_R;
      3'b001:         return M_HARD_R;
      3'b000:         return M_SEARCH;
      default:        return cur;
    endcase
  endfunction

  // One clock edge of the car's rules, using the inputs currently applied.
  task automatic model_step();
    mstate_t nxt;
    int      stop_run;
    int      clear_run;
    nxt       = m_state;
    clear_run = m_clear_run;
    stop_run  = (bus.en && bus.stop) ? m_stop_run + 1 : 0;
    if (!bus.en) begin
      nxt = M_IDLE;
    end else begin
      case (m_state)
        M_IDLE: nxt = M_FWD;
        M_HALT: nxt = M_HALT;
        M_OBSTACLE: begin
          clear_run = bus.stop ? 0 : clear_run + 1;
          if (clear_run >= RESUME_DELAY) nxt = M_FWD;
        end
        default: begin
          if (stop_run >= STOP_FILTER) nxt = M_OBSTACLE;
          else if (m_state == M_SEARCH && m_age + 1 >= SEARCH_TIMEOUT) nxt = M_HALT;
          else if (m_age >= MIN_DWELL) nxt = decode_line(bus.line_state, m_state);
        end
      endcase
    end
    if (nxt != m_state) begin
      m_age     = 0;
      clear_run = 0;
    end else begin
      m_age++;
    end
    if (nxt == M_SOFT_L || nxt == M_HARD_L) m_turn_left = 1'b1;
    if (nxt == M_SOFT_R || nxt == M_HARD_R) m_turn_left = 1'b0;
    m_state     = nxt;
    m_stop_run  = stop_run;
    m_clear_run = clear_run;
  endtask

  // Expected {left, right, mode, fsm_state} for the model's current state.
  function automatic logic [9:0] model_vec();
    logic [6:0] drv;
    logic [2:0] code;
    case (m_state)
      M_FWD:    drv = {2'b10, 2'b10, 3'd1};
      M_SOFT_L: drv = {2'b00, 2'b10, 3'd2};
      M_SOFT_R: drv = {2'b10, 2'b00, 3'd2};
      M_HARD_L: drv = {2'b01, 2'b10, 3'd3};
      M_HARD_R: drv = {2'b10, 2'b01, 3'd3};
      M_SEARCH: drv = m_turn_left ? {2'b01, 2'b10, 3'd3} : {2'b10, 2'b01, 3'd3};
      default:  drv = 7'd0;
    endcase
    code = (m_state == M_HALT) ? 3'd7 : 3'(m_state);
    return {drv, code};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic restart_fwd();
    bus.en = 1'b0;
    bus.stop = 1'b0;
    bus.line_state = 3'b010;
    tick();
    bus.en = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    bus.stop = 1'b0;
    bus.line_state = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    total++;
    if ({bus.left, bus.right, bus.mode, bus.fsm_state} !== 10'd0) begin
      bad++;
      $display("[TB] FAIL reset_state got=%b want=%b", {bus.left, bus.right, bus.mode, bus.fsm_state}, 10'd0);
    end
    rst = 1'b0;
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({bus.left, bus.right, bus.mode, bus.fsm_state} !== model_vec()) begin
        bad++;
        $display("[TB] FAIL reset_release cyc%0d got=%b want=%b", i, {bus.left, bus.right, bus.mode, bus.fsm_state}, model_vec());
      end
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.left, bus.right, bus.mode} !== 7'd0) begin
      bad++;
      $display("[TB] FAIL async_reset got=%b want=%b", {bus.left, bus.right, bus.mode}, 7'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tick();
    total++;
    if ({bus.left, bus.right, bus.mode, bus.fsm_state} !== 10'b10_10_001_001) begin
      bad++;
      $display("[TB] FAIL fwd_after_reset got=%b want=%b", {bus.left, bus.right, bus.mode, bus.fsm_state}, 10'b10_10_001_001);
    end
  endtask

  task automatic test_dwell();
    restart_fwd();
    bus.line_state = 3'b100;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) bus.line_state = 3'b101;
      tick();
      total++;
      if ({bus.left, bus.right, bus.mode, bus.fsm_state} !== model_vec()) begin
        bad++;
        $display("[TB] FAIL dwell cyc%0d got=%b want=%b", i, {bus.left, bus.right, bus.mode, bus.fsm_state}, model_vec());
      end
      if (i == 3) begin
        total++;
        if (bus.mode !== 3'd1) begin
          bad++;
          $display("[TB] FAIL dwell_hold_fwd got=%0d want=1", bus.mode);
        end
      end
    end
    total++;
    if ({bus.left, bus.right, bus.mode} !== {2'b01, 2'b10, 3'd3}) begin
      bad++;
      $display("[TB] FAIL split_holds_hard_l got=%b want=%b", {bus.left, bus.right, bus.mode}, {2'b01, 2'b10, 3'd3});
    end
  endtask

  task automatic test_search_halt();
    restart_fwd();
    bus.line_state = 3'b011;
    for (int i = 0; i < 44; i++) begin
      if (i == 6)  bus.line_state = 3'b000;
      if (i == 36) bus.line_state = 3'b010;
      tick();
      total++;
      if ({bus.left, bus.right, bus.mode, bus.fsm_state} !== model_vec()) begin
        bad++;
        $display("[TB] FAIL search cyc%0d got=%b want=%b", i, {bus.left, bus.right, bus.mode, bus.fsm_state}, model_vec());
      end
      if (m_state == M_SEARCH && i == 15) begin
        total++;
        if ({bus.left, bus.right} !== 4'b10_01) begin
          bad++;
          $display("[TB] FAIL search_dir got=%b want=1001", {bus.left, bus.right});
        end
      end
    end
    total++;
    if ({bus.mode, bus.fsm_state} !== {3'd0, 3'd7}) begin
      bad++;
      $display("[TB] FAIL halt_sticky got=%b want=%b", {bus.mode, bus.fsm_state}, {3'd0, 3'd7});
    end
    bus.en = 1'b0;
    tick();
    total++;
    if (bus.fsm_state !== 3'd0) begin
      bad++;
      $display("[TB] FAIL halt_exit_idle got=%0d want=0", bus.fsm_state);
    end
    bus.en = 1'b1;
    tick();
    total++;
    if ({bus.left, bus.right, bus.mode, bus.fsm_state} !== 10'b10_10_001_001) begin
      bad++;
      $display("[TB] FAIL halt_restart_fwd got=%b want=%b", {bus.left, bus.right, bus.mode, bus.fsm_state}, 10'b10_10_001_001);
    end
  endtask

  task automatic test_stop_filter();
    logic stop_pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    restart_fwd();
    for (int i = 0; i < 6; i++) begin
      bus.stop = stop_pat[i];
      tick();
      total++;
      if ({bus.left, bus.right, bus.mode, bus.fsm_state} !== model_vec()) begin
        bad++;
        $display("[TB] FAIL stop_filter cyc%0d got=%b want=%b", i, {bus.left, bus.right, bus.mode, bus.fsm_state}, model_vec());
      end
    end
    total++;
    if ({bus.left, bus.right, bus.mode, bus.fsm_state} !== 10'b00_00_000_111) begin
      bad++;
      $display("[TB] FAIL obstacle_mid_dwell got=%b want=%b", {bus.left, bus.right, bus.mode, bus.fsm_state}, 10'b00_00_000_111);
    end
  endtask

  task automatic test_resume();
    for (int i = 0; i < 10; i++) begin
      bus.stop = (i == 4);
      tick();
      total++;
      if ({bus.left, bus.right, bus.mode, bus.fsm_state} !== model_vec()) begin
        bad++;
        $display("[TB] FAIL resume cyc%0d got=%b want=%b", i, {bus.left, bus.right, bus.mode, bus.fsm_state}, model_vec());
      end
      if (i == 8) begin
        total++;
        if (bus.fsm_state !== 3'd7) begin
          bad++;
          $display("[TB] FAIL resume_too_early got=%0d want=7", bus.fsm_state);
        end
      end
    end
    total++;
    if (bus.fsm_state !== 3'd1) begin
      bad++;
      $display("[TB] FAIL resume_fwd got=%0d want=1", bus.fsm_state);
    end
  endtask

  task automatic test_priority();
    for (int pass = 0; pass < 2; pass++) begin
      bit hit_seen;
      hit_seen = 1'b0;
      restart_fwd();
      bus.line_state = 3'b000;
      for (int i = 0; i < 40 && !hit_seen; i++) begin
        bus.stop = (m_state == M_SEARCH) && (m_age >= SEARCH_TIMEOUT - STOP_FILTER);
        hit_seen = (m_state == M_SEARCH) && (m_age == SEARCH_TIMEOUT - 1);
        if (hit_seen && pass == 1) bus.en = 1'b0;
        tick();
        total++;
        if ({bus.left, bus.right, bus.mode, bus.fsm_state} !== model_vec()) begin
          bad++;
          $display("[TB] FAIL priority%0d cyc%0d got=%b want=%b", pass, i, {bus.left, bus.right, bus.mode, bus.fsm_state}, model_vec());
        end
      end
      total++;
      if (!hit_seen) begin
        bad++;
        $display("[TB] FAIL priority%0d_timeout got=no_collision want=collision", pass);
      end
      bus.stop = 1'b0;
      bus.en = 1'b1;
      for (int i = 0; i < RESUME_DELAY; i++) tick();
      total++;
      if ({bus.left, bus.right, bus.mode, bus.fsm_state} !== model_vec()) begin
        bad++;
        $display("[TB] FAIL priority%0d_after got=%b want=%b", pass, {bus.left, bus.right, bus.mode, bus.fsm_state}, model_vec());
      end
      total++;
      if (bus.fsm_state !== 3'd1) begin
        bad++;
        $display("[TB] FAIL priority%0d_winner got=%0d want=1", pass, bus.fsm_state);
      end
    end
  endtask

  task automatic test_random();
    restart_fwd();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) bus.line_state = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) bus.stop = ~bus.stop;
      bus.en = ($urandom_range(0, 299) != 0);
      tick();
      total++;
      if ({bus.left, bus.right, bus.mode, bus.fsm_state} !== model_vec()) begin
        bad++;
        $display("[TB] FAIL random cyc%0d got=%b want=%b", i, {bus.left, bus.right, bus.mode, bus.fsm_state}, model_vec());
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    model_reset();
    test_reset();
    test_dwell();
    test_search_halt();
    test_stop_filter();
    test_resume();
    test_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
